// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   Serialises one parallel word per frame onto a UART TX line. A frame is a
//   start bit, DATA_W data bits (LSB first), an optional even/odd parity bit
//   and one or two stop bits. Each bit lasts CLKS_PER_BIT clocks.
//   A word is taken over a valid/ready handshake. The data and frame options
//   are captured at the transfer, so later changes on the inputs do not
//   affect the frame already in flight.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous reset, active high
//   tx_valid_i     word/config valid, held by source until accepted
//   tx_ready_o     framer idle and able to accept a word
//   tx_data_i      word to transmit
//   parity_en_i    1 = append parity bit
//   parity_odd_i   1 = odd parity, 0 = even
//   stop2_i        1 = two stop bits, 0 = one
//   tx_out_o       serial line, idle high, registered
//   tx_busy_o      high from start bit through last stop bit
//   frame_done_o   one-cycle pulse in last cycle of last stop bit
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | parity bit of captured word
// STOP   | one or two stop bits (1)
module uart_tx_framer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
  input  logic              stop2_i,
  output logic              tx_out_o,
  output logic              tx_busy_o,
  output logic              frame_done_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]        state_q,    state_d;
  logic [CW-1:0]     cnt_q,      cnt_d;
  logic [IW-1:0]     idx_q,      idx_d;
  logic [DATA_W-1:0] shift_q,    shift_d;
  logic              par_q,      par_d;
  logic              par_en_q,   par_en_d;
  logic              stop2_q,    stop2_d;
  logic              stop_idx_q, stop_idx_d;
  logic              tx_out_q,   tx_out_d;

  logic bit_end;
  logic last_stop;

  assign bit_end   = (cnt_q == CNT_LAST);
  assign last_stop = (stop_idx_q == stop2_q);

  assign tx_ready_o   = (state_q == IDLE) && !rst_i;
  assign tx_busy_o    = (state_q != IDLE);
  assign frame_done_o = (state_q == STOP) && bit_end && last_stop;
  assign tx_out_o     = tx_out_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;

    case (state_q)
      IDLE: begin
        if (tx_valid_i && tx_ready_o) begin
          shift_d    = tx_data_i;
          // odd parity is the inverse of the even (XOR-reduce) bit
          par_d      = (^tx_data_i) ^ parity_odd_i;
          par_en_d   = parity_en_i;
          stop2_d    = stop2_i;
          cnt_d      = '0;
          idx_d      = '0;
          stop_idx_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (last_stop) begin
            stop_idx_d = 1'b0;
            state_d    = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d      = '0;
        idx_d      = '0;
        stop_idx_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // The line level is derived from the next state so tx_out is registered yet
  // changes in the same cycle the state does (start bit right after transfer).
  always_comb begin
    tx_out_d = 1'b1;
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
      PARITY:  tx_out_d = par_d;
      default: tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_out_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      tx_out_q   <= tx_out_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
module tb_uart_tx_framer;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int NV  = 8;

  logic          clk;
  logic          rst;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_data;
  logic          parity_en;
  logic          parity_odd;
  logic          stop2;
  logic          tx_out;
  logic          tx_busy;
  logic          frame_done;

  int checks;
  int errors;
  int xfer_cnt;
  int done_cnt;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       stop2;
    logic       hold;      // keep tx_valid high (with garbage data) during frame
    logic       exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs [NV];

  uart_tx_framer #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .tx_data_i    (tx_data),
    .parity_en_i  (parity_en),
    .parity_odd_i (parity_odd),
    .stop2_i      (stop2),
    .tx_out_o     (tx_out),
    .tx_busy_o    (tx_busy),
    .frame_done_o (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) xfer_cnt++;
      if (frame_done) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Caller has applied v's inputs with tx_valid=1 at a negedge while idle.
  // Returns at the negedge of the idle cycle following the frame.
  task automatic run_frame(input vec_t v);
    logic exp_bits [12];
    int   nb;
    logic eb;
    nb = 0;
    exp_bits[nb] = 1'b0; nb++;
    for (int i = 0; i < DW; i++) begin
      exp_bits[nb] = v.data[i]; nb++;
    end
    if (v.pen) begin
      exp_bits[nb] = v.exp_par; nb++;
    end
    exp_bits[nb] = 1'b1; nb++;
    if (v.stop2) begin
      exp_bits[nb] = 1'b1; nb++;
    end

    @(posedge clk);
    #1;
    if (!v.hold) tx_valid = 1'b0;
    tx_data    = ~v.data;
    parity_en  = ~v.pen;
    parity_odd = ~v.podd;
    stop2      = ~v.stop2;

    for (int n = 1; n <= v.exp_len + 1; n++) begin
      @(negedge clk);
      if (n <= v.exp_len) begin
        eb = ((n - 1) / CPB < nb) ? exp_bits[(n - 1) / CPB] : 1'b1;
        check("tx_out", {31'd0, tx_out}, {31'd0, eb});
        check("tx_busy", {31'd0, tx_busy}, 32'd1);
        check("tx_ready_busy", {31'd0, tx_ready}, 32'd0);
        check("frame_done", {31'd0, frame_done}, (n == v.exp_len) ? 32'd1 : 32'd0);
      end else begin
        check("idle_tx_out", {31'd0, tx_out}, 32'd1);
        check("idle_busy", {31'd0, tx_busy}, 32'd0);
        check("idle_ready", {31'd0, tx_ready}, 32'd1);
        check("idle_done", {31'd0, frame_done}, 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_before;
    checks = 0; errors = 0; xfer_cnt = 0; done_cnt = 0;

    //             data   pen   podd  stop2 hold  par   len
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 44};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 48};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 40};
    vecs[3] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 40};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 48};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 44};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 44};
    vecs[7] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 48};

    rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_out", {31'd0, tx_out}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, tx_ready}, 32'd1);

    // reset pulse while idle
    rst = 1'b1;
    #1;
    check("idle_rst_tx_out", {31'd0, tx_out}, 32'd1);
    check("idle_rst_ready", {31'd0, tx_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rst_release_ready", {31'd0, tx_ready}, 32'd1);

    // reset in the middle of the data bits of an all-zero word
    tx_data = 8'h00; tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_data_tx_out", {31'd0, tx_out}, 32'd0);
    check("mid_data_busy", {31'd0, tx_busy}, 32'd1);
    done_before = done_cnt;
    rst = 1'b1;
    #1;
    check("mid_rst_tx_out", {31'd0, tx_out}, 32'd1);
    check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    check("mid_rst_ready", {31'd0, tx_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_done", {31'd0, frame_done}, 32'd0);
      check("mid_rst_line", {31'd0, tx_out}, 32'd1);
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk);
      check("abandon_ready", {31'd0, tx_ready}, 32'd1);
      check("abandon_line", {31'd0, tx_out}, 32'd1);
      check("abandon_busy", {31'd0, tx_busy}, 32'd0);
    end
    check("abandon_no_done", done_cnt, done_before);

    for (int i = 0; i < NV; i++) begin
      tx_data    = vecs[i].data;
      parity_en  = vecs[i].pen;
      parity_odd = vecs[i].podd;
      stop2      = vecs[i].stop2;
      tx_valid   = 1'b1;
      run_frame(vecs[i]);
    end
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("final_idle_line", {31'd0, tx_out}, 32'd1);
    check("xfer_count", xfer_cnt, NV + 1);
    check("done_count", done_cnt, NV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
